regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Receiving end of the writeback interface: a 32x32 MIPS register file with
//  two combinational read ports for decode and one write port driven by the
//  writeback stage (RegWrite, des_reg, WriteData). Contains a per-register
//  pending-write scoreboard. Decode marks a destination at issue; writeback
//  retires it. Decode stalls on a read-after-write hazard that the WB bypass
//  cannot cover. Sits between decode and writeback, one instance per core.
// PARAMETERS
//  DATA_W   32  register width
//  ADDR_W   5   register address width (2**ADDR_W registers)
//  PEND_W   2   per-register in-flight writer counter width (max 3 writers)
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       asynchronous active-low reset
//  RegWrite        in   1       WB: write enable
//  des_reg         in   ADDR_W  WB: destination register
//  WriteData       in   DATA_W  WB: data to write
//  rs_addr         in   ADDR_W  decode read port A address
//  rt_addr         in   ADDR_W  decode read port B address
//  rs_data         out  DATA_W  read port A data
//  rt_data         out  DATA_W  read port B data
//  issue_valid     in   1       decode issues an instruction this cycle
//  issue_RegWrite  in   1       issued instruction writes a register
//  issue_dest      in   ADDR_W  issued instruction destination
//  stall           out  1       decode must hold; issue is ignored while high
//  pending_any     out  1       registered: some counter is nonzero
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers=0, all counters=0, pending_any=0.
//    Reset mid-operation discards any in-flight scoreboard state immediately.
//  - Register 0 reads 0. Writes to r0 are dropped. r0 is never marked pending.
//  - Write: on posedge clk, mem[des_reg] <= WriteData if RegWrite && des_reg!=0.
//  - Read: combinational, zero latency. WB bypass applies when RegWrite and
//    des_reg==addr!=0: the port returns WriteData, not the stored value.
//  - Scoreboard: cnt[r] is incremented by an accepted issue and decremented by
//    a WB retire. Accepted issue = issue_valid && issue_RegWrite &&
//    issue_dest!=0 && !stall. Retire = RegWrite && des_reg!=0 && cnt[des_reg]!=0.
//    If both events hit the same r in one cycle, cnt is unchanged.
//    A retire with cnt==0 is legal (untracked writer): data is written and cnt
//    stays 0.
//  - hazard(a) = a!=0 && (cnt[a] - retire_hit(a)) != 0. retire_hit(a)=1 when
//    the retire targets a this cycle; the last writer is then covered by the
//    bypass.
//  - stall = issue_valid && (hazard(rs_addr) || hazard(rt_addr) ||
//    (issue_RegWrite && issue_dest!=0 && cnt[issue_dest]==2**PEND_W-1 &&
//    !retire_hit(issue_dest))). The last term prevents counter overflow.
//    stall is combinational and 0 when issue_valid=0.
//  - pending_any is registered and reflects the counters after the clock edge.
// TESTING
//  1 Reset: write r5=0x11, pulse rst_n low -> rs_addr=5 reads 0; pending_any=0.
//  2 Write/read: WB r14<-0x3 in cycle N -> rs_data=0x3 in cycle N (bypass) and
//    N+1 (stored). WB r0<-0x9 -> r0 reads 0.
//  3 Hazard: issue dest=15, next cycle issue_valid with rs=15 -> stall=1. In
//    the cycle WB r15<-0x7: stall=0, rs_data=0x7.
//  4 Multiple writers: 3 issues to r31 -> 4th issue to r31 stalls. One retire
//    -> cnt=2, rt=31 still stalls. All 3 retired -> stall=0, pending_any=0.
//  5 Simultaneous: issue dest=4 and retire r4 in the same cycle with cnt=1 ->
//    cnt stays 1 and the rs=4 reader stalls the next cycle.
//  6 Mid-op reset: cnt[9]=2, assert rst_n -> stall on rs=9 drops at once;
//    r9 reads 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// 32x32 MIPS register file with a writeback bypass and a per-register
// pending-writer scoreboard that stalls decode on uncovered RAW hazards.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] des_reg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              issue_valid,
  input  logic              issue_RegWrite,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              stall,
  output logic              pending_any
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];
  logic              pending_any_q;
  logic              pending_any_d;

  logic wb_hit;
  logic retire;
  logic accept;
  logic haz_rs;
  logic haz_rt;
  logic full_block;

  // A retire on the read address removes one writer: the bypass covers it.
  always_comb begin
    wb_hit     = RegWrite && (des_reg != '0);
    retire     = wb_hit && (cnt_q[des_reg] != '0);
    haz_rs     = (rs_addr != '0) &&
                 (cnt_q[rs_addr] != PEND_W'(retire && (des_reg == rs_addr)));
    haz_rt     = (rt_addr != '0) &&
                 (cnt_q[rt_addr] != PEND_W'(retire && (des_reg == rt_addr)));
    full_block = issue_RegWrite && (issue_dest != '0) &&
                 (cnt_q[issue_dest] == CNT_MAX) &&
                 !(retire && (des_reg == issue_dest));
    stall      = issue_valid && (haz_rs || haz_rt || full_block);
    accept     = issue_valid && issue_RegWrite && (issue_dest != '0) && !stall;
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != '0) begin
      rs_data = (wb_hit && (des_reg == rs_addr)) ? WriteData : mem_q[rs_addr];
    end
    if (rt_addr != '0) begin
      rt_data = (wb_hit && (des_reg == rt_addr)) ? WriteData : mem_q[rt_addr];
    end
  end

  // Issue and retire on the same register cancel, leaving the count unchanged.
  always_comb begin
    pending_any_d = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
      cnt_d[i] = cnt_q[i];
      if (i != 0) begin
        if (wb_hit && (des_reg == ADDR_W'(i))) begin
          mem_d[i] = WriteData;
        end
        if (accept && (issue_dest == ADDR_W'(i))) begin
          cnt_d[i] = cnt_d[i] + PEND_W'(1);
        end
        if (retire && (des_reg == ADDR_W'(i))) begin
          cnt_d[i] = cnt_d[i] - PEND_W'(1);
        end
      end
      if (cnt_d[i] != '0) begin
        pending_any_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      pending_any_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      pending_any_q <= pending_any_d;
    end
  end

  assign pending_any = pending_any_q;

endmodule
